// File: rtl/lsu_dmem_bridge.sv
// RV32I load/store unit: converts the datapath's single-cycle memory request into a
// valid/ready data-bus transaction with lane alignment, write strobes and load extension.
module lsu_dmem_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        io_req_valid,
   input  logic        io_req_wen,
   input  logic [1:0]  io_req_size,
   input  logic        io_req_unsigned,
   input  logic [31:0] io_req_addr,
   input  logic [31:0] io_req_wdata,
   output logic [31:0] io_resp_rdata,
   output logic        io_stall,
   output logic        io_misaligned,
   output logic        io_fault,
   output logic        io_bus_valid,
   input  logic        io_bus_ready,
   output logic [31:0] io_bus_addr,
   output logic        io_bus_wen,
   output logic [3:0]  io_bus_wstrb,
   output logic [31:0] io_bus_wdata,
   input  logic        io_bus_rvalid,
   input  logic [31:0] io_bus_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_REQ  = 2'b01,
      S_RESP = 2'b10,
      S_DONE = 2'b11
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   state_t      state_q;
   state_t      state_d;

   logic [31:0] addr_q;
   logic [1:0]  size_q;
   logic        wen_q;
   logic        unsigned_q;
   logic [3:0]  wstrb_q;
   logic [31:0] wdata_q;
   logic [31:0] timer_q;
   logic [31:0] rdata_q;
   logic        fault_q;

   logic        misaligned;
   logic        accept;
   logic        timeout_hit;
   logic        load_capture;
   logic        set_fault;
   logic [3:0]  req_wstrb;
   logic [31:0] req_wdata;
   logic [31:0] lane_word;
   logic [31:0] load_data;

   // NOTE: every always_comb output gets a default before the case, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      misaligned = 1'b0;
      case (io_req_size)
         SZ_BYTE: misaligned = 1'b0;
         SZ_HALF: misaligned = io_req_addr[0];
         SZ_WORD: misaligned = |io_req_addr[1:0];
         default: misaligned = 1'b1;
      endcase
   end

   // Store lanes are computed from the live request and frozen at acceptance,
   // so the bus sees stable strobes/data for the whole REQ phase.
   always_comb begin
      req_wstrb = 4'b0000;
      req_wdata = 32'h0000_0000;
      case (io_req_size)
         SZ_BYTE: begin
            req_wstrb = 4'b0001 << io_req_addr[1:0];
            req_wdata = {4{io_req_wdata[7:0]}};
         end
         SZ_HALF: begin
            req_wstrb = 4'b0011 << {io_req_addr[1], 1'b0};
            req_wdata = {2{io_req_wdata[15:0]}};
         end
         default: begin
            req_wstrb = 4'b1111;
            req_wdata = io_req_wdata;
         end
      endcase
      if (!io_req_wen) begin
         req_wstrb = 4'b0000;
         req_wdata = 32'h0000_0000;
      end
   end

   always_comb begin
      lane_word = io_bus_rdata >> {addr_q[1:0], 3'b000};
      load_data = lane_word;
      case (size_q)
         SZ_BYTE: load_data = {{24{~unsigned_q & lane_word[7]}}, lane_word[7:0]};
         SZ_HALF: load_data = {{16{~unsigned_q & lane_word[15]}}, lane_word[15:0]};
         default: load_data = lane_word;
      endcase
   end

   assign accept      = (state_q == S_IDLE) && io_req_valid && !misaligned;
   assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (timer_q == TIMEOUT_CYCLES - 32'd1);

   always_comb begin
      state_d       = state_q;
      io_stall      = 1'b0;
      io_misaligned = 1'b0;
      io_bus_valid  = 1'b0;
      load_capture  = 1'b0;
      set_fault     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (io_req_valid) begin
               if (misaligned) begin
                  io_misaligned = 1'b1;
               end else begin
                  io_stall = 1'b1;
                  state_d  = S_REQ;
               end
            end
         end
         S_REQ: begin
            io_stall     = 1'b1;
            io_bus_valid = 1'b1;
            // A handshake in the same cycle as the timeout still completes normally.
            if (io_bus_ready) begin
               state_d = wen_q ? S_DONE : S_RESP;
            end else if (timeout_hit) begin
               state_d   = S_DONE;
               set_fault = 1'b1;
            end
         end
         S_RESP: begin
            io_stall = 1'b1;
            if (io_bus_rvalid) begin
               state_d      = S_DONE;
               load_capture = 1'b1;
            end else if (timeout_hit) begin
               state_d   = S_DONE;
               set_fault = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= 32'h0000_0000;
         size_q     <= 2'b00;
         wen_q      <= 1'b0;
         unsigned_q <= 1'b0;
         wstrb_q    <= 4'b0000;
         wdata_q    <= 32'h0000_0000;
         timer_q    <= 32'h0000_0000;
         rdata_q    <= 32'h0000_0000;
         fault_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         fault_q <= set_fault;
         if (accept) begin
            addr_q     <= io_req_addr;
            size_q     <= io_req_size;
            wen_q      <= io_req_wen;
            unsigned_q <= io_req_unsigned;
            wstrb_q    <= req_wstrb;
            wdata_q    <= req_wdata;
            timer_q    <= 32'h0000_0000;
         end else if ((state_q == S_REQ) || (state_q == S_RESP)) begin
            timer_q <= timer_q + 32'd1;
         end
         if (load_capture) begin
            rdata_q <= load_data;
         end else if (set_fault) begin
            rdata_q <= 32'h0000_0000;
         end
      end
   end

   assign io_bus_addr   = {addr_q[31:2], 2'b00};
   assign io_bus_wen    = wen_q;
   assign io_bus_wstrb  = wstrb_q;
   assign io_bus_wdata  = wdata_q;
   assign io_resp_rdata = rdata_q;
   assign io_fault      = fault_q;

endmodule

// File: tb/tb_lsu_dmem_bridge.sv
// Directed bench for lsu_dmem_bridge: expected bus requests and load results are queued when
// a request is driven and popped when the bridge presents the bus request or reaches DONE.
module tb_lsu_dmem_bridge;

   typedef struct packed {
      logic [31:0] addr;
      logic        wen;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } bus_exp_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        fault;
   } res_exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        io_req_valid = 1'b0;
   logic        io_req_wen = 1'b0;
   logic [1:0]  io_req_size = 2'b00;
   logic        io_req_unsigned = 1'b0;
   logic [31:0] io_req_addr = 32'h0;
   logic [31:0] io_req_wdata = 32'h0;
   logic        io_bus_ready = 1'b0;
   logic        io_bus_rvalid = 1'b0;
   logic [31:0] io_bus_rdata = 32'h0;
   logic        use_t = 1'b0;

   logic        d_req_valid, t_req_valid;
   logic [31:0] d_rdata, t_rdata, d_bus_addr, t_bus_addr, d_bus_wdata, t_bus_wdata;
   logic        d_stall, t_stall, d_mis, t_mis, d_fault, t_fault;
   logic        d_bus_valid, t_bus_valid, d_bus_wen, t_bus_wen;
   logic [3:0]  d_bus_wstrb, t_bus_wstrb;

   logic [31:0] m_rdata, m_bus_addr, m_bus_wdata;
   logic        m_stall, m_mis, m_fault, m_bus_valid, m_bus_wen;
   logic [3:0]  m_bus_wstrb;

   bus_exp_t bus_q[$];
   res_exp_t res_q[$];
   int checks = 0;
   int errors = 0;

   assign d_req_valid = io_req_valid & ~use_t;
   assign t_req_valid = io_req_valid & use_t;

   lsu_dmem_bridge #(.TIMEOUT_CYCLES(255)) dut (
      .clk(clk), .rst(rst),
      .io_req_valid(d_req_valid), .io_req_wen(io_req_wen), .io_req_size(io_req_size),
      .io_req_unsigned(io_req_unsigned), .io_req_addr(io_req_addr), .io_req_wdata(io_req_wdata),
      .io_resp_rdata(d_rdata), .io_stall(d_stall), .io_misaligned(d_mis), .io_fault(d_fault),
      .io_bus_valid(d_bus_valid), .io_bus_ready(io_bus_ready), .io_bus_addr(d_bus_addr),
      .io_bus_wen(d_bus_wen), .io_bus_wstrb(d_bus_wstrb), .io_bus_wdata(d_bus_wdata),
      .io_bus_rvalid(io_bus_rvalid), .io_bus_rdata(io_bus_rdata)
   );

   // Second instance with a short timeout for the fault scenario.
   lsu_dmem_bridge #(.TIMEOUT_CYCLES(4)) dut_t (
      .clk(clk), .rst(rst),
      .io_req_valid(t_req_valid), .io_req_wen(io_req_wen), .io_req_size(io_req_size),
      .io_req_unsigned(io_req_unsigned), .io_req_addr(io_req_addr), .io_req_wdata(io_req_wdata),
      .io_resp_rdata(t_rdata), .io_stall(t_stall), .io_misaligned(t_mis), .io_fault(t_fault),
      .io_bus_valid(t_bus_valid), .io_bus_ready(io_bus_ready), .io_bus_addr(t_bus_addr),
      .io_bus_wen(t_bus_wen), .io_bus_wstrb(t_bus_wstrb), .io_bus_wdata(t_bus_wdata),
      .io_bus_rvalid(io_bus_rvalid), .io_bus_rdata(io_bus_rdata)
   );

   assign m_rdata     = use_t ? t_rdata     : d_rdata;
   assign m_stall     = use_t ? t_stall     : d_stall;
   assign m_mis       = use_t ? t_mis       : d_mis;
   assign m_fault     = use_t ? t_fault     : d_fault;
   assign m_bus_valid = use_t ? t_bus_valid : d_bus_valid;
   assign m_bus_addr  = use_t ? t_bus_addr  : d_bus_addr;
   assign m_bus_wen   = use_t ? t_bus_wen   : d_bus_wen;
   assign m_bus_wstrb = use_t ? t_bus_wstrb : d_bus_wstrb;
   assign m_bus_wdata = use_t ? t_bus_wdata : d_bus_wdata;

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete access: IDLE cycle, ready_wait+1 REQ cycles, rvalid_wait+1 RESP cycles (loads), DONE.
   task automatic run_access(input logic sel, input logic wen, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] bus_rd,
                             input int ready_wait, input int rvalid_wait,
                             input logic [31:0] e_addr, input logic [3:0] e_wstrb,
                             input logic [31:0] e_wdata, input logic [31:0] e_rdata, input string tag);
      bus_exp_t eb;
      bus_exp_t ob;
      res_exp_t er;
      int stalls;
      eb.addr  = e_addr;
      eb.wen   = wen;
      eb.wstrb = e_wstrb;
      eb.wdata = e_wdata;
      bus_q.push_back(eb);
      if (!wen) begin
         er.rdata = e_rdata;
         er.fault = 1'b0;
         res_q.push_back(er);
      end
      @(negedge clk);
      use_t = sel;
      io_req_valid = 1'b1; io_req_wen = wen; io_req_size = size; io_req_unsigned = uns;
      io_req_addr = addr; io_req_wdata = wd;
      io_bus_ready = 1'b0; io_bus_rvalid = 1'b0;
      #1;
      stalls = int'(m_stall);
      chk({tag, "_idle_mis"}, 32'(m_mis), 32'd0);
      chk({tag, "_idle_bv"}, 32'(m_bus_valid), 32'd0);
      for (int i = 0; i <= ready_wait; i++) begin
         @(negedge clk);
         io_bus_ready  = (i == ready_wait);
         io_bus_rvalid = ~wen;
         io_bus_rdata  = 32'hBAD0_BAD0;
         #1;
         stalls += int'(m_stall);
         chk({tag, "_req_bv"}, 32'(m_bus_valid), 32'd1);
         chk({tag, "_req_addr"}, m_bus_addr, eb.addr);
         if (io_bus_ready) begin
            chk({tag, "_sb_bus"}, 32'(bus_q.size()), 32'd1);
            ob = bus_q.pop_front();
            chk({tag, "_wen"}, 32'(m_bus_wen), 32'(ob.wen));
            chk({tag, "_wstrb"}, 32'(m_bus_wstrb), 32'(ob.wstrb));
            if (wen) chk({tag, "_wdata"}, m_bus_wdata, ob.wdata);
         end
      end
      if (!wen) begin
         for (int j = 0; j <= rvalid_wait; j++) begin
            @(negedge clk);
            io_bus_ready  = 1'b0;
            io_bus_rvalid = (j == rvalid_wait);
            io_bus_rdata  = io_bus_rvalid ? bus_rd : $urandom;
            #1;
            stalls += int'(m_stall);
            chk({tag, "_resp_bv"}, 32'(m_bus_valid), 32'd0);
         end
      end
      @(negedge clk);
      io_bus_ready = 1'b0; io_bus_rvalid = 1'b0; io_bus_rdata = 32'h0;
      #1;
      chk({tag, "_done_stall"}, 32'(m_stall), 32'd0);
      chk({tag, "_done_fault"}, 32'(m_fault), 32'd0);
      chk({tag, "_latency"}, 32'(stalls), wen ? 32'(2 + ready_wait) : 32'(3 + ready_wait + rvalid_wait));
      if (!wen) begin
         chk({tag, "_sb_res"}, 32'(res_q.size()), 32'd1);
         er = res_q.pop_front();
         chk({tag, "_rdata"}, m_rdata, er.rdata);
      end
      @(negedge clk);
      io_req_valid = 1'b0;
      #1;
      chk({tag, "_no_reissue"}, 32'(m_bus_valid), 32'd0);
      chk({tag, "_idle_stall"}, 32'(m_stall), 32'd0);
   endtask

   task automatic run_misaligned(input logic wen, input logic [1:0] size, input logic [31:0] addr,
                                 input string tag);
      @(negedge clk);
      use_t = 1'b0;
      io_req_valid = 1'b1; io_req_wen = wen; io_req_size = size; io_req_unsigned = 1'b0;
      io_req_addr = addr; io_req_wdata = 32'h5555_AAAA;
      io_bus_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk({tag, "_mis"}, 32'(m_mis), 32'd1);
         chk({tag, "_stall"}, 32'(m_stall), 32'd0);
         chk({tag, "_bv"}, 32'(m_bus_valid), 32'd0);
         @(negedge clk);
      end
      io_req_valid = 1'b0; io_bus_ready = 1'b0;
      #1;
      chk({tag, "_mis_clear"}, 32'(m_mis), 32'd0);
   endtask

   initial begin
      res_exp_t er;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_d_stall", 32'(d_stall), 32'd0);
      chk("rst_d_bv", 32'(d_bus_valid), 32'd0);
      chk("rst_d_addr", d_bus_addr, 32'd0);
      chk("rst_d_wstrb", 32'(d_bus_wstrb), 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      chk("rst_d_fault", 32'(d_fault), 32'd0);
      chk("rst_t_bv", 32'(t_bus_valid), 32'd0);
      chk("rst_t_rdata", t_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      //          sel  wen   size  uns   addr          wdata         bus_rdata     rw rv  e_addr        strb     e_wdata       e_rdata
      run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         0, 0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0, "sw");
      run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00A5, 32'h0,         0, 0, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5, 32'h0, "sb");
      run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_1234, 32'h0,         0, 0, 32'h0000_0100, 4'b1100, 32'h1234_1234, 32'h0, "sh");
      run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0100, 32'h1234_567F, 32'h0,         0, 0, 32'h0000_0100, 4'b0001, 32'h7F7F_7F7F, 32'h0, "sb0");
      run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0100, 32'hFFFF_8001, 32'h0,         0, 0, 32'h0000_0100, 4'b0011, 32'h8001_8001, 32'h0, "sh0");
      run_access(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0,         32'h0000_8000, 0, 0, 32'h0000_0100, 4'b0000, 32'h0, 32'hFFFF_FF80, "lb");
      run_access(1'b0, 1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0,         32'h0000_8000, 0, 0, 32'h0000_0100, 4'b0000, 32'h0, 32'h0000_0080, "lbu");
      run_access(1'b0, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0,         32'h8001_0000, 0, 0, 32'h0000_0100, 4'b0000, 32'h0, 32'hFFFF_8001, "lh");
      run_access(1'b0, 1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0,         32'h8001_0000, 0, 0, 32'h0000_0100, 4'b0000, 32'h0, 32'h0000_8001, "lhu");
      run_access(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0,         32'h1357_9BDF, 0, 0, 32'h0000_0104, 4'b0000, 32'h0, 32'h1357_9BDF, "lw");

      run_misaligned(1'b0, 2'b10, 32'h0000_0102, "mis_lw");
      run_misaligned(1'b1, 2'b11, 32'h0000_0100, "mis_rsv");
      run_misaligned(1'b1, 2'b01, 32'h0000_0101, "mis_sh");

      // Slow bus: ready low 5 cycles, then rvalid 3 cycles after acceptance.
      run_access(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0,         32'hCAFE_F00D, 5, 2, 32'h0000_0200, 4'b0000, 32'h0, 32'hFFFF_FFCA, "slow");

      // Timeout on the short-timeout instance: prime rdata, then leave ready stuck low.
      run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0304, 32'h0,         32'h1111_2222, 0, 0, 32'h0000_0304, 4'b0000, 32'h0, 32'h1111_2222, "lw_t");
      er.rdata = 32'h0;
      er.fault = 1'b1;
      res_q.push_back(er);
      @(negedge clk);
      use_t = 1'b1;
      io_req_valid = 1'b1; io_req_wen = 1'b0; io_req_size = 2'b10; io_req_addr = 32'h0000_0308;
      io_bus_ready = 1'b0; io_bus_rvalid = 1'b0;
      #1;
      chk("to_idle_stall", 32'(m_stall), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         chk("to_req_bv", 32'(m_bus_valid), 32'd1);
         chk("to_req_stall", 32'(m_stall), 32'd1);
      end
      @(negedge clk);
      #1;
      chk("to_done_bv", 32'(m_bus_valid), 32'd0);
      chk("to_done_stall", 32'(m_stall), 32'd0);
      chk("to_sb_res", 32'(res_q.size()), 32'd1);
      er = res_q.pop_front();
      chk("to_fault", 32'(m_fault), 32'(er.fault));
      chk("to_rdata", m_rdata, er.rdata);
      @(negedge clk);
      io_req_valid = 1'b0;
      #1;
      chk("to_fault_pulse", 32'(m_fault), 32'd0);
      chk("to_idle_bv", 32'(m_bus_valid), 32'd0);

      // Reset while a load waits in RESP.
      @(negedge clk);
      use_t = 1'b0;
      io_req_valid = 1'b1; io_req_wen = 1'b0; io_req_size = 2'b10; io_req_addr = 32'h0000_0400;
      @(negedge clk);
      io_bus_ready = 1'b1;
      @(negedge clk);
      io_bus_ready = 1'b0; io_bus_rvalid = 1'b0;
      #1;
      chk("rr_resp_stall", 32'(m_stall), 32'd1);
      #1;
      rst = 1'b1;
      io_req_valid = 1'b0;
      #1;
      chk("rr_stall", 32'(m_stall), 32'd0);
      chk("rr_bv", 32'(m_bus_valid), 32'd0);
      chk("rr_addr", m_bus_addr, 32'd0);
      chk("rr_rdata", m_rdata, 32'd0);
      chk("rr_fault", 32'(m_fault), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Reset while a store is presented on the bus: valid must drop at once.
      @(negedge clk);
      io_req_valid = 1'b1; io_req_wen = 1'b1; io_req_size = 2'b10; io_req_addr = 32'h0000_0500;
      io_req_wdata = 32'h0F0F_0F0F;
      @(negedge clk);
      #1;
      chk("rq_req_bv", 32'(m_bus_valid), 32'd1);
      #1;
      rst = 1'b1;
      io_req_valid = 1'b0;
      #1;
      chk("rq_bv", 32'(m_bus_valid), 32'd0);
      chk("rq_wstrb", 32'(m_bus_wstrb), 32'd0);
      chk("rq_wdata", m_bus_wdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'h0BAD_F00D, 32'h0,         0, 0, 32'h0000_0104, 4'b1111, 32'h0BAD_F00D, 32'h0, "recover");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
